// File: rtl/lolap_iter_ctrl.sv
// Iterative round controller: accepts a 257-bit state, drives it through an
// external round datapath NR_ROUNDS times, then holds the result until taken.
// Optional abort input is enabled with LOLAP_CTRL_ABORT_EN.
module lolap_iter_ctrl #(
  parameter int NR_ROUNDS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [256:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [256:0] out_state,
  output logic [256:0] rnd_i,
  input  logic [256:0] rnd_o,
  output logic         rnd_w,
  output logic [3:0]   rnd_idx,
`ifdef LOLAP_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [256:0] st;
  logic [3:0]   idx;
  logic         last;

  assign last = (idx == 4'(NR_ROUNDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      idx   <= '0;
    end else begin
`ifdef LOLAP_CTRL_ABORT_EN
      // Abort drops the job but leaves st as-is; only the handshake is lost.
      if (abort && state != IDLE) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
`endif
      case (state)
        IDLE: if (in_valid) begin
          st    <= in_state;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          st <= rnd_o;
          if (last) state <= DONE;
          else      idx   <= idx + 4'd1;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef LOLAP_CTRL_ABORT_EN
      end
`endif
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = st;
  assign rnd_i     = st;
  assign rnd_idx   = idx;
  // Rounds 1, 3, 4 and 7 use the with-constant variant.
  assign rnd_w     = (state == RUN) &&
                     (idx == 4'd1 || idx == 4'd3 || idx == 4'd4 || idx == 4'd7);

endmodule

// File: tb/tb_lolap_iter_ctrl.sv
// Randomized self-checking bench for lolap_iter_ctrl (NR_ROUNDS=8 and =1).
module tb_lolap_iter_ctrl;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, rnd_w, busy, abort;
  logic [256:0] in_state, out_state, rnd_i, rnd_o;
  logic [3:0]   rnd_idx;

  logic         in_valid_1, in_ready_1, out_valid_1, out_ready_1, rnd_w_1, busy_1;
  logic [256:0] in_state_1, out_state_1, rnd_i_1, rnd_o_1;
  logic [3:0]   rnd_idx_1;

  int stub_mode;
  int n_cmp = 0;
  int n_bad = 0;

  // Round datapath stubs: mode 0 is a plain increment, mode 1 mixes in idx and rnd_w.
  always_comb begin
    rnd_o = rnd_i + 257'd1;
    if (stub_mode != 0)
      rnd_o = {rnd_i[255:0], rnd_i[256]} + 257'(rnd_idx) + (rnd_w ? 257'd1000 : 257'd0);
  end
  assign rnd_o_1 = rnd_i_1 + 257'd1;

  lolap_iter_ctrl #(.NR_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .rnd_i(rnd_i), .rnd_o(rnd_o), .rnd_w(rnd_w), .rnd_idx(rnd_idx),
`ifdef LOLAP_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy));

  lolap_iter_ctrl #(.NR_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_state(in_state_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_state(out_state_1),
    .rnd_i(rnd_i_1), .rnd_o(rnd_o_1), .rnd_w(rnd_w_1), .rnd_idx(rnd_idx_1),
`ifdef LOLAP_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy_1));

  function automatic bit w_of(int r);
    return (r == 1) || (r == 3) || (r == 4) || (r == 7);
  endfunction

  // Reference: apply nr rounds of the stub function to s.
  function automatic logic [256:0] model(logic [256:0] s, int mode, int nr);
    for (int r = 0; r < nr; r++) begin
      if (mode == 0) s = s + 257'd1;
      else s = {s[255:0], s[256]} + 257'(r) + (w_of(r) ? 257'd1000 : 257'd0);
    end
    return s;
  endfunction

  function automatic logic [256:0] rand257();
    logic [287:0] v;
    for (int i = 0; i < 9; i++) v[i*32 +: 32] = $urandom;
    return v[256:0];
  endfunction

  task automatic chk(input string tag, input logic [256:0] got, input logic [256:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 20) begin step(); t++; end
    if (!in_ready) chk("wait_ready_timeout", 257'(in_ready), 257'd1);
  endtask

  task automatic run_job(input logic [256:0] s, input int hold, input int mode);
    logic [256:0] exp;
    stub_mode = mode;
    exp = model(s, mode, NR);
    wait_ready();
    in_state = s; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < NR; k++) begin
      chk("run_idx", 257'(rnd_idx), 257'(k));
      chk("run_w", 257'(rnd_w), 257'(w_of(k)));
      chk("run_nvalid", 257'({out_valid, in_ready, busy}), 257'b001);
      step();
    end
    chk("done_valid", 257'(out_valid), 257'd1);
    chk("done_state", out_state, exp);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 257'({out_valid, in_ready}), 257'b10);
      chk("hold_state", out_state, exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs", 257'({out_valid, in_ready, busy}), 257'b010);
  endtask

  initial begin
    int acc, hs, vcnt;
    logic [256:0] s;
    rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0; abort = 1'b0;
    in_valid_1 = 1'b0; in_state_1 = '0; out_ready_1 = 1'b0; stub_mode = 0;
    step(); step();
    chk("rst_flags", 257'({in_ready, out_valid, busy, rnd_w}), 257'b1000);
    chk("rst_idx", 257'(rnd_idx), 257'd0);
    chk("rst_state", out_state, 257'd0);
    rst = 1'b0;
    step();

    // Directed: zero input, increment stub, then 5-cycle backpressure.
    run_job(257'd0, 0, 0);
    run_job(257'd0, 5, 0);

    for (int j = 0; j < 8; j++)
      run_job(rand257(), $urandom_range(0, 4), $urandom_range(0, 1));

    // in_valid held high: one accept per job, none before the result handshake.
    stub_mode = 0; s = rand257();
    wait_ready();
    in_state = s; in_valid = 1'b1; out_ready = 1'b1; acc = 0; hs = 0;
    for (int c = 0; c < 3 * (NR + 2); c++) begin
      if (in_ready) begin
        chk("outstanding_at_accept", 257'(acc - hs), 257'd0);
        acc++;
      end
      if (out_valid) begin
        chk("held_result", out_state, model(s, 0, NR));
        hs++;
      end
      step();
    end
    chk("held_accepts", 257'(acc), 257'd3);
    chk("held_results", 257'(hs), 257'd3);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset mid-RUN at idx=3.
    wait_ready();
    in_state = rand257(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("pre_rst_idx", 257'(rnd_idx), 257'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_flags", 257'({in_ready, out_valid, busy}), 257'b100);
    chk("async_rst_state", out_state, 257'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1; vcnt = 0;
    for (int c = 0; c < NR + 4; c++) begin
      if (out_valid) vcnt++;
      step();
    end
    out_ready = 1'b0;
    chk("rst_no_result", 257'(vcnt), 257'd0);
    chk("rst_idle", 257'(in_ready), 257'd1);

    // Single-round instance.
    in_state_1 = 257'd5; in_valid_1 = 1'b1;
    step();
    in_valid_1 = 1'b0;
    chk("nr1_run", 257'({out_valid_1, busy_1, rnd_idx_1}), 257'({1'b0, 1'b1, 4'd0}));
    step();
    chk("nr1_valid", 257'(out_valid_1), 257'd1);
    chk("nr1_state", out_state_1, 257'd6);
    out_ready_1 = 1'b1;
    step();
    out_ready_1 = 1'b0;
    chk("nr1_idle", 257'(in_ready_1), 257'd1);

`ifdef LOLAP_CTRL_ABORT_EN
    stub_mode = 0;
    wait_ready();
    in_state = 257'd0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("abort_idx", 257'(rnd_idx), 257'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle", 257'({in_ready, out_valid, busy}), 257'b100);
    chk("abort_st", out_state, 257'd2);
    out_ready = 1'b1; vcnt = 0;
    for (int c = 0; c < NR + 4; c++) begin
      if (out_valid) vcnt++;
      step();
    end
    out_ready = 1'b0;
    chk("abort_no_result", 257'(vcnt), 257'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
